mpt_fetch_stage: RTL and testbench

//  Memory-read stage of the MPT walker, one instance per walking level, placed before parsing_stage.
//  - Input: an mptw_transaction_t whose mpte field carries the next MPTE physical address.
//  - Issues one 64-bit read on the memory request port.
//  - Writes the returned MPT entry into mpte and forwards the transaction downstream.
//  - Bus errors and response timeouts are turned into access errors; the rest of the walk is skipped.

---
 rtl/mpt_fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_mpt_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpt_fetch_stage.sv
// rtl/mpt_fetch_stage.sv - MPT walker memory-read stage (one instance per walking level)
//
// Takes one walker transaction, reads the 64-bit MPT entry at its mpte address,
// writes the entry back into mpte and forwards the transaction. Bus errors and
// response timeouts become access errors that skip the rest of the walk.
//
// Packed transaction layout (LSB first):
//   [0]            valid
//   [2:1]          walking        (0 = IDLE, 1 = DO, 2 = SKIP)
//   [3]            access_error
//   [4]            plb_hit
//   [5]            format_error
//   [7:6]          access_type
//   [8 +: MPTE_W]  mpte           (MPTE_W = min(XLEN, width-8))
//   [above mpte]   mmpt/spa/rpa   opaque, carried through untouched
//
// Ports:
//   clk_i, rst_ni                          clock, asynchronous active-low reset
//   stage_slave_valid/ready/data           upstream transaction handshake
//   stage_master_valid/ready/data          downstream transaction handshake
//   mem_req_o/gnt_i/addr_o/we_o/be_o       read request channel
//   mem_valid_i/rdata_i/error_i            read response channel
//   mem_fault_o                            one-cycle pulse on bus error or timeout
//   busy_o                                 stage holds a transaction

module mpt_fetch_stage #(
  parameter int PIPELINE_SLAVE_DATA_WIDTH  = 32,
  parameter int PIPELINE_MASTER_DATA_WIDTH = 32,
  parameter int WALKING_LEVEL              = 0,
  parameter int MEM_DATA_WIDTH             = 64,
  parameter int TIMEOUT_CYCLES             = 256
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  stage_slave_valid,
  output logic                                  stage_slave_ready,
  input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  stage_slave_data,
  output logic                                  stage_master_valid,
  input  logic                                  stage_master_ready,
  output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] stage_master_data,
  output logic                                  mem_req_o,
  input  logic                                  mem_gnt_i,
  output logic [MEM_DATA_WIDTH-1:0]             mem_addr_o,
  output logic                                  mem_we_o,
  output logic [7:0]                            mem_be_o,
  input  logic                                  mem_valid_i,
  input  logic [63:0]                           mem_rdata_i,
  input  logic                                  mem_error_i,
  output logic                                  mem_fault_o,
  output logic                                  busy_o
);

  localparam int XLEN = MEM_DATA_WIDTH;
  localparam int PSDW = PIPELINE_SLAVE_DATA_WIDTH;
  localparam int PMDW = PIPELINE_MASTER_DATA_WIDTH;

  localparam int VALID_BIT  = 0;
  localparam int WALK_LSB   = 1;
  localparam int AERR_BIT   = 3;
  localparam int MPTE_LSB   = 8;
  localparam int MPTE_W     = ((PSDW - MPTE_LSB) < XLEN) ? (PSDW - MPTE_LSB) : XLEN;

  localparam logic [1:0] MPT_WALKING_SKIP = 2'd2;

  // Counter must be able to hold TIMEOUT_CYCLES; keep at least one bit so the
  // timeout-disabled configuration still elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  logic [1:0]      state_q;
  logic [PSDW-1:0] txn_q;
  logic [CNT_W-1:0] cnt_q;

  logic            accept;
  logic            in_skip;
  logic            rsp;
  logic            timeout;
  logic [XLEN-1:0] mpte_addr;

  // Sinks for bits that only matter in some configurations.
  logic rdata_unused;
  logic level_unused;
  assign rdata_unused = ^mem_rdata_i;
  assign level_unused = (WALKING_LEVEL != 0);

  assign stage_slave_ready = rst_ni && (state_q == ST_IDLE);
  assign accept            = stage_slave_valid && stage_slave_ready;
  assign in_skip           = !stage_slave_data[VALID_BIT] ||
                             (stage_slave_data[WALK_LSB +: 2] == MPT_WALKING_SKIP);

  // Responses are only meaningful in WAIT; anything else on the response
  // channel (including the grant cycle) is dropped.
  assign rsp     = (state_q == ST_WAIT) && mem_valid_i;
  // A response on the last allowed cycle takes priority over the timeout.
  assign timeout = TO_EN && (state_q == ST_WAIT) && !mem_valid_i && (cnt_q == TO_LAST);

  assign mpte_addr = XLEN'(txn_q[MPTE_LSB +: MPTE_W]);

  assign mem_req_o   = (state_q == ST_REQ);
  assign mem_addr_o  = (state_q == ST_REQ) ? {mpte_addr[XLEN-1:3], 3'b000} : '0;
  assign mem_we_o    = 1'b0;
  assign mem_be_o    = 8'hFF;
  assign mem_fault_o = (rsp && mem_error_i) || timeout;

  assign stage_master_valid = (state_q == ST_OUT);
  assign stage_master_data  = PMDW'(txn_q);
  assign busy_o             = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      txn_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            txn_q   <= stage_slave_data;
            state_q <= in_skip ? ST_OUT : ST_REQ;
          end
        end

        ST_REQ: begin
          if (mem_gnt_i) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
          end
        end

        ST_WAIT: begin
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (rsp) begin
            txn_q[MPTE_LSB +: MPTE_W] <= mem_rdata_i[MPTE_W-1:0];
            if (mem_error_i) begin
              txn_q[AERR_BIT]       <= 1'b1;
              txn_q[WALK_LSB +: 2]  <= MPT_WALKING_SKIP;
            end
            state_q <= ST_OUT;
          end else if (timeout) begin
            txn_q[MPTE_LSB +: MPTE_W] <= '0;
            txn_q[AERR_BIT]           <= 1'b1;
            txn_q[WALK_LSB +: 2]      <= MPT_WALKING_SKIP;
            state_q                   <= ST_OUT;
          end
        end

        ST_OUT: begin
          if (stage_master_ready) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpt_fetch_stage.sv
// tb/tb_mpt_fetch_stage.sv - directed self-checking bench for mpt_fetch_stage

module tb_mpt_fetch_stage;

  localparam int DW = 96;
  localparam logic [1:0] WDO   = 2'd1;
  localparam logic [1:0] WSKIP = 2'd2;

  logic          clk;
  logic          rst_n;
  logic          slave_valid;
  logic          slave_ready;
  logic [DW-1:0] slave_data;
  logic          master_valid;
  logic          master_ready;
  logic [DW-1:0] master_data;
  logic          mem_req;
  logic          mem_gnt;
  logic [63:0]   mem_addr;
  logic          mem_we;
  logic [7:0]    mem_be;
  logic          mem_valid;
  logic [63:0]   mem_rdata;
  logic          mem_error;
  logic          mem_fault;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;

  mpt_fetch_stage #(
    .PIPELINE_SLAVE_DATA_WIDTH (DW),
    .PIPELINE_MASTER_DATA_WIDTH(DW),
    .WALKING_LEVEL             (1),
    .MEM_DATA_WIDTH            (64),
    .TIMEOUT_CYCLES            (4)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .stage_slave_valid (slave_valid),
    .stage_slave_ready (slave_ready),
    .stage_slave_data  (slave_data),
    .stage_master_valid(master_valid),
    .stage_master_ready(master_ready),
    .stage_master_data (master_data),
    .mem_req_o         (mem_req),
    .mem_gnt_i         (mem_gnt),
    .mem_addr_o        (mem_addr),
    .mem_we_o          (mem_we),
    .mem_be_o          (mem_be),
    .mem_valid_i       (mem_valid),
    .mem_rdata_i       (mem_rdata),
    .mem_error_i       (mem_error),
    .mem_fault_o       (mem_fault),
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req && mem_gnt) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_txn(input logic [23:0] upper, input logic [63:0] mpte,
                                           input logic [1:0] atype, input logic fe, input logic plb,
                                           input logic aerr, input logic [1:0] walk, input logic vld);
    return {upper, mpte, atype, fe, plb, aerr, walk, vld};
  endfunction

  task automatic accept_txn(input logic [DW-1:0] t);
    @(negedge clk);
    slave_valid = 1'b1;
    slave_data  = t;
    @(negedge clk);
    slave_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    master_ready = 1'b1;
    @(negedge clk);
    master_ready = 1'b0;
    check({tag, "_mv_done"}, master_valid, 1'b0);
    check({tag, "_ready_back"}, slave_ready, 1'b1);
  endtask

  logic [DW-1:0] t;
  logic [63:0]   addr_exp;
  int            hs0;

  initial begin
    rst_n = 1'b0; slave_valid = 1'b0; slave_data = '0; master_ready = 1'b0;
    mem_gnt = 1'b0; mem_valid = 1'b0; mem_rdata = '0; mem_error = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_ready", slave_ready, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_mv", master_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", master_data, '0);
    check("rst_be", mem_be, 8'hFF);
    check("rst_we", mem_we, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", slave_ready, 1'b1);

    // 1: normal fetch, gnt and rvalid each one cycle late -> master valid 3 cycles after accept
    t = mk_txn(24'hA5A5A5, 64'h0000_0000_8000_1008, 2'd2, 1'b0, 1'b1, 1'b0, WDO, 1'b1);
    hs0 = hs_cnt;
    accept_txn(t);
    check("t1_req", mem_req, 1'b1);
    check("t1_addr", mem_addr, 64'h0000_0000_8000_1008);
    check("t1_ready_busy", slave_ready, 1'b0);
    check("t1_mv_c1", master_valid, 1'b0);
    @(negedge clk);
    check("t1_req_c2", mem_req, 1'b1);
    check("t1_mv_c2", master_valid, 1'b0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("t1_req_wait", mem_req, 1'b0);
    check("t1_mv_c3", master_valid, 1'b0);
    mem_valid = 1'b1; mem_rdata = 64'h0000_0000_0000_0011;
    @(negedge clk);
    mem_valid = 1'b0;
    check("t1_mv_lat3", master_valid, 1'b1);
    check("t1_data", master_data, mk_txn(24'hA5A5A5, 64'h11, 2'd2, 1'b0, 1'b1, 1'b0, WDO, 1'b1));
    check("t1_hs", hs_cnt - hs0, 1);
    drain("t1");

    // 2: skip path -> no memory access, unchanged, 1 cycle
    t = mk_txn(24'h123456, 64'h0000_0000_9000_0000, 2'd1, 1'b1, 1'b0, 1'b0, WSKIP, 1'b1);
    hs0 = hs_cnt;
    accept_txn(t);
    check("t2_mv", master_valid, 1'b1);
    check("t2_req", mem_req, 1'b0);
    check("t2_data", master_data, t);
    drain("t2");
    // invalid transaction takes the same bypass
    t = mk_txn(24'h00FF00, 64'h0000_0000_9000_0040, 2'd3, 1'b0, 1'b0, 1'b0, WDO, 1'b0);
    accept_txn(t);
    check("t2b_mv", master_valid, 1'b1);
    check("t2b_req", mem_req, 1'b0);
    check("t2b_data", master_data, t);
    check("t2_no_hs", hs_cnt - hs0, 0);
    drain("t2b");

    // 3: grant withheld 5 cycles -> request/address stable, one handshake
    t = mk_txn(24'h0F0F0F, 64'h0000_0001_4000_2237, 2'd3, 1'b0, 1'b0, 1'b0, WDO, 1'b1);
    addr_exp = 64'h0000_0001_4000_2230;
    hs0 = hs_cnt;
    accept_txn(t);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_req_%0d", i), mem_req, 1'b1);
      check($sformatf("t3_addr_%0d", i), mem_addr, addr_exp);
      @(negedge clk);
    end
    check("t3_req_gnt", mem_req, 1'b1);
    check("t3_addr_gnt", mem_addr, addr_exp);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("t3_req_drop", mem_req, 1'b0);
    mem_valid = 1'b1; mem_rdata = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    mem_valid = 1'b0;
    check("t3_mv", master_valid, 1'b1);
    check("t3_data", master_data, mk_txn(24'h0F0F0F, 64'hCAFE_F00D_1234_5678, 2'd3, 1'b0, 1'b0, 1'b0, WDO, 1'b1));
    @(negedge clk);
    check("t3_hold_mv", master_valid, 1'b1);
    check("t3_hold_data", master_data, mk_txn(24'h0F0F0F, 64'hCAFE_F00D_1234_5678, 2'd3, 1'b0, 1'b0, 1'b0, WDO, 1'b1));
    check("t3_hs", hs_cnt - hs0, 1);
    drain("t3");

    // 4: bus error -> access_error, SKIP, one-cycle fault
    t = mk_txn(24'h777777, 64'h0000_0000_8000_3000, 2'd1, 1'b0, 1'b1, 1'b0, WDO, 1'b1);
    accept_txn(t);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    mem_valid = 1'b1; mem_error = 1'b1; mem_rdata = 64'h0000_0000_0000_DEAD;
    #1;
    check("t4_fault_hi", mem_fault, 1'b1);
    @(negedge clk);
    mem_valid = 1'b0; mem_error = 1'b0;
    #1;
    check("t4_fault_lo", mem_fault, 1'b0);
    check("t4_mv", master_valid, 1'b1);
    check("t4_data", master_data, mk_txn(24'h777777, 64'hDEAD, 2'd1, 1'b0, 1'b1, 1'b1, WSKIP, 1'b1));
    drain("t4");

    // 5: timeout after 4 WAIT cycles, late response ignored
    t = mk_txn(24'h314159, 64'h0000_0000_8000_4010, 2'd0, 1'b0, 1'b0, 1'b0, WDO, 1'b1);
    accept_txn(t);
    mem_gnt = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      @(negedge clk);
      mem_gnt = 1'b0;
      #1;
      check($sformatf("t5_fault_w%0d", w), mem_fault, (w == 4));
      check($sformatf("t5_mv_w%0d", w), master_valid, 1'b0);
    end
    @(negedge clk);
    check("t5_mv", master_valid, 1'b1);
    check("t5_data", master_data, mk_txn(24'h314159, 64'h0, 2'd0, 1'b0, 1'b0, 1'b1, WSKIP, 1'b1));
    mem_valid = 1'b1; mem_rdata = 64'h0000_0000_0000_BEEF;
    #1;
    check("t5_late_fault", mem_fault, 1'b0);
    @(negedge clk);
    mem_valid = 1'b0;
    check("t5_late_data", master_data, mk_txn(24'h314159, 64'h0, 2'd0, 1'b0, 1'b0, 1'b1, WSKIP, 1'b1));
    drain("t5");

    // 6: reset during WAIT, response after release is ignored
    t = mk_txn(24'h2468AC, 64'h0000_0000_8000_5000, 2'd2, 1'b0, 1'b0, 1'b0, WDO, 1'b1);
    accept_txn(t);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("t6_in_wait", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", slave_ready, 1'b0);
    check("t6_rst_req", mem_req, 1'b0);
    check("t6_rst_addr", mem_addr, 64'h0);
    check("t6_rst_mv", master_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_fault", mem_fault, 1'b0);
    check("t6_rst_data", master_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_valid = 1'b1; mem_rdata = 64'h55;
    #1;
    check("t6_late_fault", mem_fault, 1'b0);
    @(negedge clk);
    mem_valid = 1'b0;
    check("t6_busy", busy, 1'b0);
    check("t6_mv", master_valid, 1'b0);
    check("t6_ready", slave_ready, 1'b1);
    @(negedge clk);
    check("t6_mv_after", master_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
